// File: rtl/uart_tx_ctrl.sv
// UART transmit control: frame FSM, LSB-first serializer and parity for the TX output mux.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame (default: one stop bit).
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [2:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    // The state encoding doubles as the mux select code.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        SER    = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } state_t;

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_en_q;
    logic                    stop_last;
    logic                    ser_last;
    logic                    accept;

`ifdef UART_TX_TWO_STOP_EN
    // Distinguishes the first from the second stop cycle.
    logic stop_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stop_cnt <= 1'b0;
        end else if (state == STOP) begin
            stop_cnt <= ~stop_cnt;
        end else begin
            stop_cnt <= 1'b0;
        end
    end

    assign stop_last = (state == STOP) && stop_cnt;
`else
    assign stop_last = (state == STOP);
`endif

    assign ser_last = (state == SER) && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign mux_sel  = state;
    assign ser_data = shift_reg[0];

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    accept     = 1'b1;
                    next_state = START;
                end
            end
            START: next_state = SER;
            SER: begin
                if (ser_last) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: next_state = STOP;
            STOP: begin
                if (stop_last) begin
                    if (Data_Valid) begin
                        accept     = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (state == SER) begin
            bit_cnt <= ser_last ? '0 : bit_cnt + 1'b1;
        end else begin
            bit_cnt <= '0;
        end
    end

    // Word and frame settings are captured only at acceptance and held for the frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_reg <= '0;
            par_bit   <= 1'b0;
            par_en_q  <= 1'b0;
        end else if (accept) begin
            shift_reg <= P_DATA;
            par_bit   <= (^P_DATA) ^ PAR_TYP;
            par_en_q  <= PAR_EN;
        end else if (state == SER) begin
            shift_reg <= shift_reg >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized self-checking bench for uart_tx_ctrl against a frame-level reference model.
// Honours UART_TX_TWO_STOP_EN for the expected stop length.
module tb_uart_tx_ctrl;

    localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [2:0]   mux_sel;
    logic         ser_data;
    logic         par_bit;
    logic         busy;

    int checks = 0;
    int passes = 0;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic [W-1:0] data, input logic pe, input logic pt);
        P_DATA     = data;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        step();
    endtask

    // Walks one frame from its START cycle; the expected frame is built from the
    // field layout (start, data LSB first, optional parity, stop). dv_mode sets the
    // mid-frame input noise: 0 random, 1 valid held high, 2 valid pulsing with all-ones data.
    task automatic run_frame(input logic [W-1:0] data, input logic pe, input logic pt,
                             input int dv_mode, input logic next_valid,
                             input logic [W-1:0] next_data, input logic next_pe,
                             input logic next_pt, input string name);
        logic [2:0] exp_sel [$];
        logic       exp_ser [$];
        logic       exp_par;
        int         len;
        exp_par = pt ? ~(^data) : (^data);
        exp_sel.push_back(3'b001);
        exp_ser.push_back(1'b0);
        for (int j = 0; j < W; j++) begin
            exp_sel.push_back(3'b010);
            exp_ser.push_back(data[j]);
        end
        if (pe) begin
            exp_sel.push_back(3'b011);
            exp_ser.push_back(1'b0);
        end
        for (int j = 0; j < NSTOP; j++) begin
            exp_sel.push_back(3'b100);
            exp_ser.push_back(1'b0);
        end
        len = exp_sel.size();
        for (int i = 0; i < len; i++) begin
            checks++;
            if (mux_sel !== exp_sel[i])
                $display("[TB] FAIL %s mux_sel cycle %0d: got %b want %b", name, i, mux_sel, exp_sel[i]);
            else
                passes++;
            checks++;
            if (busy !== 1'b1)
                $display("[TB] FAIL %s busy cycle %0d: got %b want 1", name, i, busy);
            else
                passes++;
            checks++;
            if (par_bit !== exp_par)
                $display("[TB] FAIL %s par_bit cycle %0d: got %b want %b", name, i, par_bit, exp_par);
            else
                passes++;
            if (exp_sel[i] == 3'b010) begin
                checks++;
                if (ser_data !== exp_ser[i])
                    $display("[TB] FAIL %s ser_data cycle %0d: got %b want %b", name, i, ser_data, exp_ser[i]);
                else
                    passes++;
            end
            if (i == len - 1) begin
                Data_Valid = next_valid;
                P_DATA     = next_data;
                PAR_EN     = next_pe;
                PAR_TYP    = next_pt;
            end else begin
                case (dv_mode)
                    0: begin
                        Data_Valid = 1'($urandom_range(0, 1));
                        P_DATA     = W'($urandom);
                    end
                    1: begin
                        Data_Valid = 1'b1;
                        P_DATA     = W'($urandom);
                    end
                    default: begin
                        Data_Valid = i[0];
                        P_DATA     = '1;
                    end
                endcase
                PAR_EN  = 1'($urandom_range(0, 1));
                PAR_TYP = 1'($urandom_range(0, 1));
            end
            step();
        end
        if (!next_valid) begin
            checks++;
            if (mux_sel !== 3'b000 || busy !== 1'b0)
                $display("[TB] FAIL %s end idle: got mux_sel=%b busy=%b want 000/0", name, mux_sel, busy);
            else
                passes++;
            Data_Valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST        = 1'b1;
        P_DATA     = '0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #3;
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0 || ser_data !== 1'b0 || par_bit !== 1'b0)
            $display("[TB] FAIL reset outputs: got sel=%b busy=%b ser=%b par=%b want 000/0/0/0",
                     mux_sel, busy, ser_data, par_bit);
        else
            passes++;
        #14;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mux_sel !== 3'b000 || busy !== 1'b0)
                $display("[TB] FAIL reset idle hold: got sel=%b busy=%b want 000/0", mux_sel, busy);
            else
                passes++;
        end
    endtask

    task automatic test_even_parity();
        start_frame(8'hA5, 1'b1, 1'b0);
        run_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0, "even_parity");
    endtask

    task automatic test_odd_parity();
        start_frame(8'h03, 1'b1, 1'b1);
        run_frame(8'h03, 1'b1, 1'b1, 0, 1'b0, '0, 1'b0, 1'b0, "odd_parity");
    endtask

    task automatic test_no_parity();
        start_frame(8'h03, 1'b0, 1'b1);
        run_frame(8'h03, 1'b0, 1'b1, 0, 1'b0, '0, 1'b0, 1'b0, "no_parity");
    endtask

    task automatic test_back_to_back();
        start_frame(8'h55, 1'b1, 1'b0);
        run_frame(8'h55, 1'b1, 1'b0, 1, 1'b1, 8'hF0, 1'b1, 1'b1, "b2b_first");
        run_frame(8'hF0, 1'b1, 1'b1, 0, 1'b0, '0, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_ignored_valid();
        start_frame(8'h00, 1'b1, 1'b0);
        run_frame(8'h00, 1'b1, 1'b0, 2, 1'b0, '0, 1'b0, 1'b0, "ignored_valid");
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'hB7, 1'b1, 1'b1);
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (mux_sel !== 3'b010)
            $display("[TB] FAIL midreset pre sel: got %b want 010", mux_sel);
        else
            passes++;
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0 || ser_data !== 1'b0 || par_bit !== 1'b0)
            $display("[TB] FAIL midreset outputs: got sel=%b busy=%b ser=%b par=%b want 000/0/0/0",
                     mux_sel, busy, ser_data, par_bit);
        else
            passes++;
        #2;
        RST = 1'b0;
        step();
        checks++;
        if (mux_sel !== 3'b000 || busy !== 1'b0)
            $display("[TB] FAIL midreset no resume: got sel=%b busy=%b want 000/0", mux_sel, busy);
        else
            passes++;
        start_frame(8'h3C, 1'b0, 1'b0);
        run_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0, "after_midreset");
    endtask

    task automatic test_random();
        logic [W-1:0] d, nd;
        logic         pe, pt, npe, npt, nv;
        d  = W'($urandom);
        pe = 1'($urandom_range(0, 1));
        pt = 1'($urandom_range(0, 1));
        start_frame(d, pe, pt);
        for (int k = 0; k < 8; k++) begin
            nd  = W'($urandom);
            npe = 1'($urandom_range(0, 1));
            npt = 1'($urandom_range(0, 1));
            nv  = (k == 7) ? 1'b0 : 1'($urandom_range(0, 1));
            run_frame(d, pe, pt, 0, nv, nd, npe, npt, $sformatf("random_%0d", k));
            if (!nv && k != 7) begin
                step();
                start_frame(nd, npe, npt);
            end
            d  = nd;
            pe = npe;
            pt = npt;
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_back_to_back();
        test_ignored_valid();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Upstream control stage of the UART transmitter; drives the TX output mux.
- Accepts a parallel byte with a valid strobe and sequences the frame: start, data bits LSB-first, optional parity, stop.
- Integrates the frame FSM, the serializer shift register and the parity calculator.
- Outputs mux_sel, ser_data and par_bit, which feed the output mux directly. The mux turns them into the serial line.

Parameters:
- DATA_WIDTH, default 8: number of data bits per frame; legal range 5..9.

Ports:
- CLK  input  1  TX bit clock; one frame bit per cycle.
- RST  input  1  asynchronous reset, active-high.
- P_DATA  input  DATA_WIDTH  parallel data to transmit.
- Data_Valid  input  1  P_DATA valid; single-cycle or held.
- PAR_EN  input  1  1 = include parity bit in the frame.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- mux_sel  output  3  frame-field select: 000 idle, 001 start, 010 ser, 011 parity, 100 stop.
- ser_data  output  1  current data bit, LSB first.
- par_bit  output  1  parity bit of the latched word.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Clock and reset: one clock domain (CLK); reset is asynchronous, active-high (RST).
- Reset values: mux_sel=000, ser_data=0, par_bit=0, busy=0, bit counter=0, shift register=0, state=IDLE.
- FSM states: IDLE, START, SER, PARITY, STOP. mux_sel is the registered state encoding and changes only on CLK rising edges.
- Acceptance:
  - Data_Valid is sampled in IDLE and in the final STOP cycle.
  - On acceptance, P_DATA goes into the shift register and PAR_EN/PAR_TYP are latched.
  - par_bit is computed from P_DATA at the same edge: even = XOR-reduce, odd = inverted XOR-reduce. It is held for the whole frame.
  - The next state is START.
- Data_Valid in START/SER/PARITY, or in a non-final STOP cycle, is ignored; latched data and settings are unchanged.
- START lasts 1 cycle, then goes to SER.
- SER:
  - Lasts exactly DATA_WIDTH cycles.
  - ser_data = shift_reg[0] throughout; the register shifts right at the end of each SER cycle.
  - The counter counts 0..DATA_WIDTH-1 and clears on exit.
  - Exit goes to PARITY if latched PAR_EN=1, otherwise to STOP.
- PARITY lasts 1 cycle, then goes to STOP.
- STOP exit, final STOP cycle:
  - If Data_Valid=1, the new word is accepted and the next state is START (back-to-back, no idle gap).
  - Otherwise the next state is IDLE.
- busy is registered; it is 1 whenever state != IDLE and goes 0 in the same cycle mux_sel returns to 000.
- Latency: Data_Valid high at edge k gives mux_sel=001 from edge k to edge k+1. The first data bit is presented after edge k+1.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles. For DATA_WIDTH=8 this is 11 cycles with parity, 10 without.
- Reset mid-frame: all state aborts at once and outputs return to reset values; no partial frame resumes after RST deasserts.
- PAR_EN and PAR_TYP changing mid-frame have no effect on the current frame.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles; Data_Valid acceptance happens only in the second STOP cycle; frame length grows by 1.
- Undefined: single stop bit, as above.

Test Plan:
- Even parity: RST pulse, then P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid.
  - mux_sel sequence: 001, 010 x8, 011, 100, 000.
  - ser_data during SER: 1,0,1,0,0,1,0,1.
  - par_bit=0; busy high for exactly 11 cycles.
- Odd parity: P_DATA=8'h03, PAR_TYP=1, PAR_EN=1 -> par_bit=1 through the frame.
- No parity: P_DATA=8'h03, PAR_EN=0 -> no 011 state, 10-cycle frame, STOP follows the 8th SER cycle.
- Back-to-back: Data_Valid held high, words 8'h55 then 8'hF0.
  - After 100, mux_sel goes straight to 001; busy stays high with no gap.
  - Second word's ser_data is 0,0,0,0,1,1,1,1.
- Ignored valid: Data_Valid pulses with P_DATA=8'hFF during the SER of 8'h00 -> transmitted bits all 0; frame ends in IDLE.
- Reset mid-frame: assert RST during the 4th SER cycle -> mux_sel=000 and busy=0 at once, without a clock edge; a new accept afterwards produces a complete, correct frame.
